// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANTED, OWNED, RELEASE} arb_state_t;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from i_ptr upward, modulo N.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Outer loop walks the priority order; inner loop keeps every bit select constant.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!o_any && i_req[i] && (((int'(i_ptr) + k) % N) == i)) begin
          o_any       = 1'b1;
          o_idx       = IW'(i);
          o_onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared memory request bus: grant FSM with timeout,
// one dead turnaround cycle between owners, payload mux and sticky protocol-error flag.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int GRANT_TIMEOUT  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                in_abtr_reqcyc,
  input  logic [NUM_REQ-1:0]                in_bus_busy,
  input  logic [NUM_REQ-1:0]                in_m_bus_reqcyc,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] in_m_bus_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  in_m_bus_reqtag,
  output logic [NUM_REQ-1:0]                out_grant,
  output logic [owner_w(NUM_REQ)-1:0]       out_owner,
  output logic                              out_owner_valid,
  output logic                              out_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]         out_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]          out_bus_reqtag,
  output logic                              out_proto_err
);

  localparam int OW = owner_w(NUM_REQ);
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_rr_ptr;
  logic                r_owner_valid;
  logic [TW-1:0]       r_timer;
  logic                r_proto_err;

  logic [NUM_REQ-1:0]        w_pick_onehot;
  logic [OW-1:0]             w_pick_idx;
  logic                      w_pick_any;
  logic [OW-1:0]             w_next_ptr;
  logic [OW-1:0]             w_pick_ptr;
  logic                      w_own_busy;
  logic                      w_own_req;
  logic                      w_own_strobe;
  logic [BUS_DATA_WIDTH-1:0] w_own_req_dat;
  logic [BUS_TAG_WIDTH-1:0]  w_own_tag;
  logic                      w_busy_bad;

  assign w_next_ptr = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + OW'(1);
  // Arbitrating during RELEASE with the advanced pointer keeps the dead gap at one cycle.
  assign w_pick_ptr = (r_state == RELEASE) ? w_next_ptr : r_rr_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_rr_pick (
    .i_req    (in_abtr_reqcyc),
    .i_ptr    (w_pick_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_comb begin
    w_own_busy    = 1'b0;
    w_own_req     = 1'b0;
    w_own_strobe  = 1'b0;
    w_own_req_dat = '0;
    w_own_tag     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner_valid && (r_owner == OW'(i))) begin
        w_own_busy    = in_bus_busy[i];
        w_own_req     = in_abtr_reqcyc[i];
        w_own_strobe  = in_m_bus_reqcyc[i];
        w_own_req_dat = in_m_bus_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        w_own_tag     = in_m_bus_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
      end
    end
  end

  // r_grant is zero whenever there is no valid owner, so this also catches busy in IDLE/RELEASE.
  assign w_busy_bad = |(in_bus_busy & ~r_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_owner_valid <= 1'b0;
      r_timer       <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_busy_bad) r_proto_err <= 1'b1;
      case (r_state)
        IDLE, RELEASE: begin
          if (r_state == RELEASE) r_rr_ptr <= w_next_ptr;
          if (w_pick_any) begin
            r_state       <= GRANTED;
            r_grant       <= w_pick_onehot;
            r_owner       <= w_pick_idx;
            r_owner_valid <= 1'b1;
            r_timer       <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANTED: begin
          if (w_own_busy) begin
            r_state <= OWNED;
          end else if (!w_own_req || (r_timer == TW'(GRANT_TIMEOUT - 1))) begin
            r_state       <= RELEASE;
            r_grant       <= '0;
            r_owner_valid <= 1'b0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        OWNED: begin
          if (!w_own_busy) begin
            r_state       <= RELEASE;
            r_grant       <= '0;
            r_owner_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_grant       = r_grant;
  assign out_owner       = r_owner;
  assign out_owner_valid = r_owner_valid;
  assign out_bus_reqcyc  = r_owner_valid & w_own_strobe;
  assign out_bus_req     = w_own_req_dat;
  assign out_bus_reqtag  = w_own_tag;
  assign out_proto_err   = r_proto_err;

endmodule
